// File: rtl/fpu_issue_ctrl.sv
// FP command queue and issue sequencer in front of the FP register-file unit.
// Buffers core commands, issues them one at a time and returns results.
module fpu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_op,
  input  logic [4:0]  cmd_x1,
  input  logic [4:0]  cmd_x2,
  input  logic [4:0]  cmd_y,
  input  logic [31:0] cmd_data,
  output logic [5:0]  fpu_operation,
  output logic [4:0]  fpu_x1,
  output logic [4:0]  fpu_x2,
  output logic [4:0]  fpu_y,
  output logic [31:0] fpu_in_data,
  output logic        fpu_ready,
  input  logic        fpu_valid,
  input  logic        fpu_out_data1,
  input  logic [31:0] fpu_out_data32,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_op,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [1:0]  err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [5:0] OP_FCLT = 6'b100000;
  localparam logic [5:0] OP_FCZ  = 6'b101000;
  localparam logic [5:0] OP_FTOI = 6'b111000;
  localparam logic [5:0] OP_GET  = 6'b111111;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [4:0]  y;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010,
      6'b000101, 6'b000110, 6'b010000,
      6'b100000, 6'b101000, 6'b111000,
      6'b111001, 6'b111110, 6'b111111:
        op_legal = 1'b1;
      default:
        op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_rsp(input logic [5:0] op);
    op_rsp = (op == OP_FCLT) || (op == OP_FCZ) ||
             (op == OP_FTOI) || (op == OP_GET);
  endfunction

  function automatic logic op_bit(input logic [5:0] op);
    op_bit = (op == OP_FCLT) || (op == OP_FCZ);
  endfunction

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          ne_q;
  logic          full;
  logic          acc;
  logic          push;
  logic          drop;
  logic          pop;
  state_t        state;
  logic [CW-1:0] cnt;

  assign full      = count == (AW+1)'(DEPTH);
  assign cmd_ready = !full;
  assign acc       = cmd_valid && !full;
  assign push      = acc && op_legal(cmd_op);
  assign drop      = acc && !op_legal(cmd_op);
  assign head      = mem[rptr];
  assign busy      = (count != '0) || (state != IDLE);

  // Head waits while its result would land on an unconsumed response.
  assign pop = (state == IDLE) && ne_q && (count != '0) &&
               !(op_rsp(head.op) && rsp_valid);

  // Command storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cmd_op, cmd_x1, cmd_x2, cmd_y, cmd_data};
  end

  // FIFO pointers, occupancy and the delayed non-empty view seen by IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ne_q  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ne_q <= count != '0;
    end
  end

  // Issue sequencer with registered fpu drive, response buffer and errors.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      fpu_ready     <= 1'b0;
      fpu_operation <= OP_GET;
      fpu_x1        <= '0;
      fpu_x2        <= '0;
      fpu_y         <= '0;
      fpu_in_data   <= '0;
      rsp_valid     <= 1'b0;
      rsp_op        <= '0;
      rsp_data      <= '0;
      err           <= '0;
    end else begin
      if (drop) err[1] <= 1'b1;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state         <= ISSUE;
            cnt           <= '0;
            fpu_ready     <= 1'b1;
            fpu_operation <= head.op;
            fpu_x1        <= head.x1;
            fpu_x2        <= head.x2;
            fpu_y         <= head.y;
            fpu_in_data   <= head.data;
          end
        end
        ISSUE: begin
          if (fpu_valid) begin
            if (op_rsp(fpu_operation)) begin
              rsp_valid <= 1'b1;
              rsp_op    <= fpu_operation;
              rsp_data  <= op_bit(fpu_operation) ?
                           {31'b0, fpu_out_data1} : fpu_out_data32;
            end
            state         <= DRAIN;
            fpu_ready     <= 1'b0;
            fpu_operation <= OP_GET;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err[0]        <= 1'b1;
            state         <= DRAIN;
            fpu_ready     <= 1'b0;
            fpu_operation <= OP_GET;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state         <= IDLE;
          fpu_ready     <= 1'b0;
          fpu_operation <= OP_GET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: fpu stub with a real-valued register file,
// queue-level model of issue order, handshake timing and responses.
module tb_fpu_issue_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  localparam logic [5:0] FADD = 6'b000000;
  localparam logic [5:0] FSUB = 6'b000001;
  localparam logic [5:0] FMUL = 6'b000010;
  localparam logic [5:0] FABS = 6'b000101;
  localparam logic [5:0] FMOV = 6'b000110;
  localparam logic [5:0] FNEG = 6'b010000;
  localparam logic [5:0] FCLT = 6'b100000;
  localparam logic [5:0] FCZ  = 6'b101000;
  localparam logic [5:0] FTOI = 6'b111000;
  localparam logic [5:0] ITOF = 6'b111001;
  localparam logic [5:0] SET  = 6'b111110;
  localparam logic [5:0] GET  = 6'b111111;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_op;
  logic [4:0]  cmd_x1;
  logic [4:0]  cmd_x2;
  logic [4:0]  cmd_y;
  logic [31:0] cmd_data;
  logic [5:0]  fpu_operation;
  logic [4:0]  fpu_x1;
  logic [4:0]  fpu_x2;
  logic [4:0]  fpu_y;
  logic [31:0] fpu_in_data;
  logic        fpu_ready;
  logic        fpu_valid;
  logic        fpu_out_data1;
  logic [31:0] fpu_out_data32;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [5:0]  rsp_op;
  logic [31:0] rsp_data;
  logic        busy;
  logic [1:0]  err;

  fpu_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x1(cmd_x1), .cmd_x2(cmd_x2),
    .cmd_y(cmd_y), .cmd_data(cmd_data),
    .fpu_operation(fpu_operation), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
    .fpu_y(fpu_y), .fpu_in_data(fpu_in_data), .fpu_ready(fpu_ready),
    .fpu_valid(fpu_valid), .fpu_out_data1(fpu_out_data1),
    .fpu_out_data32(fpu_out_data32),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op(rsp_op), .rsp_data(rsp_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc  = 0;
  int nvec = 0;
  int nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // ---------------- fpu stub ----------------
  function automatic real dec(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] enc(input real v);
    real         a;
    int          e;
    logic        s;
    logic [7:0]  ef;
    logic [22:0] m;
    if (v == 0.0) return 32'h0;
    s = v < 0.0;
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    ef = 8'(e + 127);
    m  = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, ef, m};
  endfunction

  function automatic int lat(input logic [5:0] op);
    case (op)
      FADD, FSUB:             lat = 2;
      FMUL:                   lat = 3;
      FCLT, FCZ, FTOI, ITOF:  lat = 1;
      default:                lat = 0;
    endcase
  endfunction

  real  srf [32];
  int   lc;
  logic stub_hang;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) lc <= 0;
    else if (fpu_ready) lc <= lc + 1;
    else lc <= 0;
  end

  assign fpu_valid = fpu_ready && !(stub_hang && fpu_operation == ITOF) &&
                     (lc == lat(fpu_operation));

  always @(posedge clk) begin
    if (fpu_ready && fpu_valid) begin
      case (fpu_operation)
        FADD: srf[fpu_y] <= srf[fpu_x1] + srf[fpu_x2];
        FSUB: srf[fpu_y] <= srf[fpu_x1] - srf[fpu_x2];
        FMUL: srf[fpu_y] <= srf[fpu_x1] * srf[fpu_x2];
        FABS: srf[fpu_y] <= (srf[fpu_x1] < 0.0) ? -srf[fpu_x1] : srf[fpu_x1];
        FMOV: srf[fpu_y] <= srf[fpu_x1];
        FNEG: srf[fpu_y] <= -srf[fpu_x1];
        ITOF: srf[fpu_y] <= real'($signed(fpu_in_data));
        SET:  srf[fpu_y] <= dec(fpu_in_data);
        default: ;
      endcase
    end
  end

  always_comb begin
    fpu_out_data1  = 1'b0;
    fpu_out_data32 = 32'h0;
    case (fpu_operation)
      GET:  fpu_out_data32 = enc(srf[fpu_x1]);
      FTOI: fpu_out_data32 = 32'($rtoi(srf[fpu_x1]));
      FCLT: fpu_out_data1  = srf[fpu_x1] < srf[fpu_x2];
      FCZ:  fpu_out_data1  = srf[fpu_x1] == 0.0;
      default: ;
    endcase
  end

  // ---------------- model ----------------
  function automatic logic legal(input logic [5:0] op);
    case (op)
      FADD, FSUB, FMUL, FABS, FMOV, FNEG,
      FCLT, FCZ, FTOI, ITOF, SET, GET: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic logic has_rsp(input logic [5:0] op);
    return op == FCLT || op == FCZ || op == FTOI || op == GET;
  endfunction

  logic [52:0] mq [$];
  logic [37:0] exp_q [$];

  // Compare process: checks outputs on every cycle out of reset.
  initial begin
    logic        prev_ready;
    logic        prev_rv;
    logic        prev_rr;
    logic [52:0] snap;
    logic [37:0] rsnap;
    logic [5:0]  cur_op;
    int          hi_len;
    int          low_len;
    int          vcyc;
    logic        had_issue;
    prev_ready = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0;
    snap = '0; rsnap = '0; cur_op = GET;
    hi_len = 0; low_len = 0; vcyc = 0; had_issue = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_ready = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0;
        had_issue = 1'b0; hi_len = 0; low_len = 0;
      end else begin
        if (!fpu_ready) chk("idle_op", 64'(fpu_operation), 64'(GET));
        if (fpu_ready && !prev_ready) begin
          if (mq.size() == 0) bad("issue_from_empty");
          else begin
            chk("issue_cmd",
                64'({fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data}),
                64'(mq[0]));
            cur_op = mq[0][52:47];
            void'(mq.pop_front());
          end
          if (had_issue) chk("gap_ge2", 64'(low_len >= 2), 64'd1);
          had_issue = 1'b1;
          hi_len = 0;
          snap = {fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data};
        end
        if (fpu_ready) begin
          chk("issue_stable",
              64'({fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data}),
              64'(snap));
          hi_len++;
          if (fpu_valid) vcyc = cyc;
        end
        if (!fpu_ready && prev_ready) begin
          chk("ready_len", 64'(hi_len),
              64'((cur_op == ITOF && stub_hang) ? TIMEOUT : lat(cur_op) + 1));
          low_len = 0;
        end
        if (!fpu_ready) low_len++;
        chk("cmd_ready", 64'(cmd_ready), 64'(mq.size() < DEPTH));
        chk("busy", 64'(busy),
            64'(mq.size() > 0 || fpu_ready || prev_ready));
        if (rsp_valid && !prev_rv) begin
          chk("rsp_lat", 64'(cyc), 64'(vcyc + 1));
          if (exp_q.size() == 0) bad("rsp_unexpected");
        end
        if (prev_rv && !prev_rr)
          chk("rsp_hold", 64'({rsp_valid, rsp_op, rsp_data}),
              64'({1'b1, rsnap}));
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) bad("rsp_extra");
          else begin
            chk("rsp", 64'({rsp_op, rsp_data}), 64'(exp_q[0]));
            void'(exp_q.pop_front());
          end
        end
        rsnap = {rsp_op, rsp_data};
        prev_ready = fpu_ready;
        prev_rv = rsp_valid;
        prev_rr = rsp_ready;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] y,
                      input logic [31:0] d, input logic [31:0] ed);
    int t;
    t = 0;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_x1 = a; cmd_x2 = b; cmd_y = y; cmd_data = d;
    while (!cmd_ready && t < 300) begin step(); t++; end
    if (!cmd_ready) begin
      bad("send_wait");
      cmd_valid = 1'b0;
      return;
    end
    step();
    cmd_valid = 1'b0;
    if (legal(op)) mq.push_back({op, a, b, y, d});
    if (legal(op) && has_rsp(op)) exp_q.push_back({op, ed});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((busy || rsp_valid) && t < 500) begin step(); t++; end
    chk("drain", 64'(busy || rsp_valid), 64'd0);
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    while (!rsp_valid && t < 100) begin step(); t++; end
    if (!rsp_valid) bad("rsp_wait");
  endtask

  initial begin
    int t;
    int t1_acc;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_x1 = '0;
    cmd_x2 = '0; cmd_y = '0; cmd_data = '0; rsp_ready = 1'b1;
    stub_hang = 1'b0;
    repeat (3) step();
    chk("rst_fpu_ready", 64'(fpu_ready), 64'd0);
    chk("rst_fpu_op", 64'(fpu_operation), 64'(GET));
    chk("rst_fpu_fields", 64'({fpu_x1, fpu_x2, fpu_y, fpu_in_data}), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_op, rsp_data}), 64'd0);
    chk("rst_busy_err", 64'({busy, err}), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    rstn = 1'b1;
    step();

    // SET/GET round trip with first-issue latency
    send(SET, 0, 0, 3, 32'h3F800000, 0);
    t1_acc = cyc;
    t = 0;
    while (!fpu_ready && t < 20) begin step(); t++; end
    chk("first_lat", 64'(cyc - t1_acc), 64'd2);
    send(GET, 3, 0, 0, 0, 32'h3F800000);
    drain();

    // Arithmetic chain
    send(SET, 0, 0, 1, 32'h3F800000, 0);
    send(SET, 0, 0, 2, 32'h40000000, 0);
    send(FADD, 1, 2, 4, 0, 0);
    send(GET, 4, 0, 0, 0, 32'h40400000);
    send(FMUL, 2, 2, 5, 0, 0);
    send(GET, 5, 0, 0, 0, 32'h40800000);
    drain();

    // Response back-pressure blocks the next result-producing op
    rsp_ready = 1'b0;
    send(FCLT, 1, 2, 0, 0, 32'd1);
    send(FTOI, 2, 0, 0, 0, 32'd2);
    wait_rsp();
    chk("fclt_op", 64'(rsp_op), 64'(FCLT));
    chk("fclt_data", 64'(rsp_data), 64'd1);
    repeat (5) begin
      step();
      chk("ftoi_held", 64'(fpu_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    t = 0;
    do begin step(); t++; end
    while (!(rsp_valid && rsp_op == FTOI) && t < 50);
    chk("ftoi_data", 64'(rsp_data), 64'd2);
    drain();

    // Fill the FIFO behind a pending response
    rsp_ready = 1'b0;
    send(GET, 1, 0, 0, 0, 32'h3F800000);
    wait_rsp();
    send(GET, 2, 0, 0, 0, 32'h40000000);
    send(GET, 3, 0, 0, 0, 32'h3F800000);
    send(GET, 4, 0, 0, 0, 32'h40400000);
    send(GET, 5, 0, 0, 0, 32'h40800000);
    chk("full_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1; cmd_op = GET; cmd_x1 = 5'd1;
    repeat (3) begin
      step();
      chk("full_hold", 64'({cmd_ready, fpu_ready}), 64'd0);
    end
    rsp_ready = 1'b1;
    send(GET, 1, 0, 0, 0, 32'h3F800000);
    drain();

    // Illegal opcode, then timeout
    send(6'b000011, 1, 1, 1, 32'hDEAD, 0);
    step();
    chk("err_illegal", 64'(err), 64'd2);
    send(SET, 0, 0, 7, 32'h41200000, 0);
    send(GET, 7, 0, 0, 0, 32'h41200000);
    drain();
    stub_hang = 1'b1;
    send(ITOF, 0, 0, 8, 32'd5, 0);
    drain();
    chk("err_timeout", 64'(err), 64'd3);
    stub_hang = 1'b0;
    send(ITOF, 0, 0, 9, 32'd3, 0);
    send(GET, 9, 0, 0, 0, 32'h40400000);
    drain();

    // Asynchronous reset mid-ISSUE
    send(FMUL, 2, 2, 5, 0, 0);
    t = 0;
    while (!fpu_ready && t < 20) begin step(); t++; end
    chk("fmul_issued", 64'(fpu_ready), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_fpu", 64'({fpu_ready, fpu_operation}), 64'({1'b0, GET}));
    chk("arst_fields", 64'({fpu_x1, fpu_x2, fpu_y, fpu_in_data}), 64'd0);
    chk("arst_rsp_busy_err", 64'({rsp_valid, busy, err}), 64'd0);
    chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    mq.delete();
    exp_q.delete();
    step();
    #2;
    rstn = 1'b1;
    step();
    send(SET, 0, 0, 6, 32'h40A00000, 0);
    send(GET, 6, 0, 0, 0, 32'h40A00000);
    drain();
    chk("end_err", 64'(err), 64'd0);
    chk("end_queues", 64'(mq.size() + exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
